// File: rtl/fifo_8x64.sv
// fifo_8x64: 64x8 synchronous FIFO, registered flags and read data; define FIFO_8X64_STATUS_EN for count/overflow/underflow outputs
module fifo_8x64 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_8X64_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  wr_ok, rd_ok;
  // next-state for pointers, occupancy, read data and flags
  always_comb begin
    wr_ok   = wr_en && !full_q;
    rd_ok   = rd_en && !empty_q;
    wptr_d  = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd_ok ? rptr_q + 1'b1 : rptr_q;
    cnt_d   = (wr_ok && !rd_ok) ? cnt_q + 1'b1 : (rd_ok && !wr_ok) ? cnt_q - 1'b1 : cnt_q;
    dout_d  = rd_ok ? mem[rptr_q] : dout_q;
    full_d  = cnt_d == FULL_CNT;
    empty_d = cnt_d == '0;
  end
  // control state register; reset empties the queue but leaves storage alone
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end
  // storage array, written only on an accepted write outside reset
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr_q] <= data_in;
  end
  assign data_out = dout_q;
  assign full     = full_q;
  assign empty    = empty_q;
`ifdef FIFO_8X64_STATUS_EN
  logic ovf_q, unf_q;
  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & full_q);
      unf_q <= unf_q | (rd_en & empty_q);
    end
  end
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif
endmodule

// File: tb/tb_fifo_8x64.sv
// tb_fifo_8x64: directed plus randomized check of fifo_8x64 against a queue model
module tb_fifo_8x64;
  logic       clk, rst, wr_en, rd_en;
  logic [7:0] data_in, data_out;
  logic       full, empty;
`ifdef FIFO_8X64_STATUS_EN
  logic [6:0] count;
  logic       overflow, underflow;
`endif
  fifo_8x64 dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty)
`ifdef FIFO_8X64_STATUS_EN
    , .count(count), .overflow(overflow), .underflow(underflow)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] q[$];
  logic [7:0] exp_dout;
  bit         exp_ovf, exp_unf;
  int         n_vec, n_err;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic rs);
    int n;
    wr_en = w; rd_en = r; data_in = d; rst = rs;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete(); exp_dout = 8'h00; exp_ovf = 0; exp_unf = 0;
    end else begin
      if (w && n == 64) exp_ovf = 1;
      if (r && n == 0) exp_unf = 1;
      if (r && n > 0) exp_dout = q.pop_front();
      if (w && n < 64) q.push_back(d);
    end
    #1;
    chk("data_out", data_out, exp_dout);
    chk("full", full, q.size() == 64);
    chk("empty", empty, q.size() == 0);
`ifdef FIFO_8X64_STATUS_EN
    chk("count", count, q.size());
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_unf);
`endif
    wr_en = 0; rd_en = 0; rst = 0;
  endtask
  initial begin
    wr_en = 0; rd_en = 0; data_in = 0; rst = 0; exp_dout = 0;
    cyc(0, 0, 0, 1);
    for (int i = 1; i <= 64; i++) cyc(1, 0, 8'(i), 0);
    cyc(1, 0, 8'd65, 0);
    for (int i = 0; i < 65; i++) cyc(0, 1, 0, 0);
    chk("drain_last", data_out, 8'd64);
    for (int i = 0; i < 40; i++) cyc(1, 0, 8'(i + 100), 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 50; i++) cyc(1, 0, 8'(8'hA0 + i), 0);
    for (int i = 0; i < 50; i++) cyc(0, 1, 0, 0);
    chk("wrap_last", data_out, 8'hA0 + 8'd49);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'(i + 1), 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'(i + 8'h30), 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 8'h77, 0);
    cyc(0, 1, 0, 0);
    chk("empty_both", data_out, 8'h77);
    for (int i = 0; i < 64; i++) cyc(1, 0, 8'(i ^ 8'h5A), 0);
    cyc(1, 1, 8'hEE, 0);
    for (int i = 0; i < 64; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc(1, 0, 8'(i), 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 8'h55, 0);
    cyc(0, 1, 0, 0);
    chk("post_rst", data_out, 8'h55);
    for (int i = 0; i < 4000; i++) begin
      int pw;
      pw = ((i / 300) % 2 == 0) ? 75 : 25;
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw,
          8'($urandom), $urandom_range(0, 499) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
